// File: rtl/alu_mem_stage.sv
// Execute/memory stage: registered ALU + address generation (E), then data-memory access
// and result select (M); result2 feeds register write-back, dbg_data peeks memory.
module alu_mem_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry,
  output logic                  illegal_op,
  input  logic [ADDR_BITS-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int SH    = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] b_mux;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH:0]   wide;
  logic                  alu_c;
  logic                  alu_ill;

  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  sel1_q;
  logic                  w_r_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  m_addr;

  always_comb begin
    b_mux   = sel3 ? offset : operand2;
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (opcode)
      4'b0000: begin
        wide    = {1'b0, operand1} + {1'b0, b_mux};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_c   = wide[DATA_WIDTH];
      end
      4'b0001: begin
        // top bit of the widened difference is the unsigned borrow
        wide    = {1'b0, operand1} - {1'b0, b_mux};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_c   = wide[DATA_WIDTH];
      end
      4'b0010: alu_res = operand1 & b_mux;
      4'b0011: alu_res = operand1 | b_mux;
      4'b0100: alu_res = operand1 ^ b_mux;
      4'b0101: alu_res = ~operand1;
      4'b0110: alu_res = operand1 << b_mux[SH-1:0];
      4'b0111: alu_res = operand1 >> b_mux[SH-1:0];
      4'b1000: alu_res = operand1;
      4'b1001: alu_res = b_mux;
      4'b1010: alu_res = {{(DATA_WIDTH-1){1'b0}}, operand1 < b_mux};
      4'b1111: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q      <= '0;
      b_q        <= '0;
      sel1_q     <= 1'b1;
      w_r_q      <= 1'b0;
      zero       <= 1'b1;
      carry      <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      alu_q      <= alu_res;
      b_q        <= operand2;
      sel1_q     <= sel1;
      w_r_q      <= w_r;
      zero       <= (alu_res == '0);
      carry      <= alu_c;
      illegal_op <= alu_ill;
    end
  end

  // upper ALU bits are dropped, so addresses wrap around the memory
  assign m_addr = alu_q[ADDR_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_q <= mem[m_addr];
      if (w_r_q) mem[m_addr] <= b_q;
    end
  end

  assign result2  = sel1_q ? alu_q : rd_q;
  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_alu_mem_stage.sv
// Randomised and directed bench for alu_mem_stage against an arithmetic reference model.
// Outputs are compared every cycle at posedge+3; directed checks sit at posedge+2.
module tb_alu_mem_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] operand1 = '0;
  logic [7:0] operand2 = '0;
  logic [7:0] offset = '0;
  logic [3:0] opcode = '0;
  logic       sel1 = 1'b1;
  logic       sel3 = 1'b0;
  logic       w_r = 1'b0;
  logic [7:0] result2;
  logic       zero;
  logic       carry;
  logic       illegal_op;
  logic [4:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int nchk = 0;
  int npass = 0;
  bit cmp_en = 1'b0;

  alu_mem_stage dut (
    .clk(clk), .rst(rst),
    .operand1(operand1), .operand2(operand2),
    .offset(offset), .opcode(opcode),
    .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .result2(result2), .zero(zero),
    .carry(carry), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
  endtask

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int r, output int c, output int ill);
    int s;
    r = 0; c = 0; ill = 0;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = (a * (1 << (b % 8))) % 256;
      7: r = a / (1 << (b % 8));
      8: r = a;
      9: r = b;
      10: r = (a < b) ? 1 : 0;
      15: r = 0;
      default: ill = 1;
    endcase
  endfunction

  // reference: word store, previous-cycle ALU address/data/request, expected outputs
  int mem_m [32];
  int p_addr, p_b, p_wr;
  int e_r2, e_z, e_c, e_ill;

  always @(posedge clk or posedge rst) begin
    int r, c, ill, rd, bv;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 0;
      p_addr = 0; p_b = 0; p_wr = 0;
      e_r2 = 0; e_z = 1; e_c = 0; e_ill = 0;
    end else begin
      bv = sel3 ? int'(offset) : int'(operand2);
      ref_alu(int'(operand1), bv, int'(opcode), r, c, ill);
      rd = mem_m[p_addr];
      if (p_wr != 0) mem_m[p_addr] = p_b;
      e_r2  = sel1 ? r : rd;
      e_z   = (r == 0) ? 1 : 0;
      e_c   = c;
      e_ill = ill;
      p_addr = r % 32;
      p_b    = int'(operand2);
      p_wr   = int'(w_r);
    end
  end

  always @(posedge clk) begin
    #3;
    if (cmp_en && !rst) begin
      chk("result2", int'(result2), e_r2);
      chk("zero", int'(zero), e_z);
      chk("carry", int'(carry), e_c);
      chk("illegal_op", int'(illegal_op), e_ill);
      chk("dbg_data", int'(dbg_data), mem_m[dbg_addr]);
    end
  end

  task automatic apply(input int a, input int b, input int off, input int op,
                       input bit s1, input bit s3, input bit wr);
    @(negedge clk);
    operand1 = 8'(a); operand2 = 8'(b); offset = 8'(off);
    opcode = 4'(op); sel1 = s1; sel3 = s3; w_r = wr;
    @(posedge clk);
    #2;
  endtask

  task automatic hold_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic sweep(input string nm, input int a3, input int a7);
    int ex;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_addr = 5'(i);
      #1;
      ex = (i == 3) ? a3 : (i == 7) ? a7 : 0;
      chk(nm, int'(dbg_data), ex);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_result2", int'(result2), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_carry", int'(carry), 0);
    chk("rst_ill", int'(illegal_op), 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    apply(3, 2, 0, 0, 1, 0, 0);
    chk("add_3_2", int'(result2), 5);
    chk("add_3_2_zero", int'(zero), 0);
    chk("add_3_2_carry", int'(carry), 0);
    chk("model_add", e_r2, 5);
    apply(200, 100, 0, 0, 1, 0, 0);
    chk("add_ovf", int'(result2), 44);
    chk("add_ovf_carry", int'(carry), 1);
    chk("model_ovf", e_r2, 44);
    apply(2, 3, 0, 1, 1, 0, 0);
    chk("sub_2_3", int'(result2), 255);
    chk("sub_borrow", int'(carry), 1);

    // asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_result2", int'(result2), 0);
    chk("async_zero", int'(zero), 1);
    chk("async_carry", int'(carry), 0);
    @(negedge clk);
    operand1 = '0; operand2 = '0; offset = '0; opcode = '0;
    sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
    rst = 1'b0;
    sweep("rst_mem", 0, 0);

    apply(4, 8'hA5, 3, 0, 1, 1, 1);
    hold_edge();
    @(negedge clk);
    dbg_addr = 5'd7;
    #1;
    chk("store_a5", int'(dbg_data), 8'hA5);
    apply(4, 8'hA5, 3, 0, 0, 1, 0);
    hold_edge();
    chk("load_a5", int'(result2), 8'hA5);
    chk("model_load", e_r2, 8'hA5);

    apply(30, 8'h3C, 5, 0, 1, 1, 1);
    hold_edge();
    apply(0, 0, 0, 12, 1, 0, 0);
    chk("illegal_r2", int'(result2), 0);
    chk("illegal_flag", int'(illegal_op), 1);
    sweep("wrap_mem", 8'h3C, 8'hA5);

    apply(77, 0, 0, 15, 1, 0, 0);
    chk("nop_r2", int'(result2), 0);
    chk("nop_ill", int'(illegal_op), 0);
    chk("nop_zero", int'(zero), 1);
    apply(8'h81, 1, 0, 6, 1, 0, 0);
    chk("shl_81", int'(result2), 2);

    // reset while a store is pending in the M stage
    apply(9, 8'h77, 0, 0, 1, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_r2", int'(result2), 0);
    repeat (2) @(negedge clk);
    operand1 = '0; operand2 = '0; offset = '0; opcode = '0;
    sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_r2b", int'(result2), 0);
    sweep("mid_rst_mem", 0, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      offset   = 8'($urandom);
      opcode   = 4'($urandom);
      sel1     = 1'($urandom);
      sel3     = 1'($urandom);
      w_r      = ($urandom_range(0, 3) == 0);
      dbg_addr = 5'($urandom);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/alu_mem_stage.md
Name: alu_mem_stage

Overview:
- Execute/memory datapath directly downstream of the control unit.
- Consumes the control unit's operand1, operand2, offset, opcode, sel1, sel3 and w_r; computes an ALU result; performs data-memory load/store; returns result2 for register write-back.
- Two registered stages:
  - E: ALU and address generation.
  - M: memory access and result select.

Parameters:
DATA_WIDTH, 8, width of operands, offset, ALU result and memory words
ADDR_BITS, 5, data-memory address width; depth = 2**ADDR_BITS (32 words)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset
operand1  input  DATA_WIDTH  ALU A input / base address
operand2  input  DATA_WIDTH  ALU B input (sel3=0) / store data
offset  input  DATA_WIDTH  address offset, ALU B input when sel3=1
opcode  input  4  ALU operation
sel1  input  1  1: result2 = ALU result; 0: result2 = memory read data
sel3  input  1  1: ALU B = offset; 0: ALU B = operand2
w_r  input  1  1: store request
result2  output  DATA_WIDTH  write-back value to control unit
zero  output  1  registered ALU result == 0
carry  output  1  registered carry/borrow
illegal_op  output  1  registered, opcode not in the defined set
dbg_addr  input  ADDR_BITS  debug read address
dbg_data  output  DATA_WIDTH  combinational mem[dbg_addr]

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high.
- Reset values:
  - alu_q, b_q, rd_q, result2: 0.
  - sel1_q=1, w_r_q=0.
  - zero=1, carry=0, illegal_op=0.
  - All memory words 0.
  - Reset mid-operation discards any pending store.
- ALU inputs: A=operand1, B = sel3 ? offset : operand2.
- ALU opcodes, all results truncated to DATA_WIDTH:
  - 0000 ADD, carry = carry-out.
  - 0001 SUB A-B, carry = borrow (A<B unsigned).
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 NOT A.
  - 0110 SHL A by B[$clog2(DATA_WIDTH)-1:0]; 0111 SHR (logical), same amount.
  - 1000 pass A; 1001 pass B.
  - 1010 SLT unsigned (1 if A<B else 0).
  - 1111 NOP, result 0.
  - All others: result 0, illegal_op=1.
  - carry=0 for every opcode except ADD/SUB.
- Stage E, every edge:
  - alu_q <= ALU(A,B); b_q <= operand2.
  - sel1_q <= sel1; w_r_q <= w_r.
  - zero, carry, illegal_op updated from the same ALU evaluation.
- Stage M, every edge:
  - Address = alu_q[ADDR_BITS-1:0]; upper bits ignored, so addresses wrap mod 2**ADDR_BITS.
  - If w_r_q=1: mem[addr] <= b_q.
  - rd_q <= mem[addr], read-before-write: a same-cycle write to the same address returns the old word.
- result2 is combinational from registers: sel1_q ? alu_q : rd_q.
- Latency:
  - ALU result valid on result2 one edge after inputs are applied.
  - Load data valid two edges after inputs, provided inputs are held for both edges (the control unit holds them through DECODE..WRITE_BACK).
  - A store commits on the second edge with w_r held high.
  - Holding w_r longer rewrites the same word; this is idempotent.
- w_r=1 with sel3=0 is legal: the address is the ALU result of operand1/operand2.
- dbg_data reflects memory contents after the last edge; no read side effects.
- No handshake back-pressure: inputs are sampled every cycle; the upstream FSM sequences them.

Test Plan:
- Reset: pulse rst asynchronously mid-cycle -> result2=0, zero=1, carry=0 immediately; dbg_addr sweep 0..31 reads 0.
- ALU ops:
  - operand1=3, operand2=2, opcode=0000, sel1=1, sel3=0 -> after 1 edge result2=5, zero=0, carry=0.
  - 200+100 -> result2=44, carry=1.
  - 2-3 SUB -> result2=255, carry=1.
- Store then load:
  - operand1=4, offset=3, operand2=0xA5, opcode=0000, sel3=1, w_r=1, held 2 edges -> dbg_addr=7 reads 0xA5.
  - Then same with w_r=0, sel1=0, held 2 edges -> result2=0xA5.
- Wrap: operand1=30, offset=5, store 0x3C -> mem[3]=0x3C; mem[35&31] only, no other word changed.
- Opcodes:
  - opcode=1100 -> result2=0, illegal_op=1.
  - opcode=1111 -> result2=0, illegal_op=0, zero=1.
  - SHL 0x81 by 1 -> 0x02.
- Reset mid-store: w_r_q=1 pending, assert rst before the M edge -> no write occurs, memory all zero, result2=0.
